sht30_meas_sched: RTL and testbench

//   Sequences an SHT30 through an I2C byte engine (sht30_i2c_byte, one op per handshake):

---
 rtl/sht30_pkg.sv | 63 ++++++
 rtl/sht30_crc8.sv | 21 ++
 rtl/sht30_meas_sched.sv | 215 +++++++++++++++++++++
 tb/tb_sht30_meas_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sht30_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sht30_pkg: op encodings, sensor command words, CRC constants, states  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sht30_pkg;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [15:0] CMD_SOFT_RST = 16'h30A2;
  localparam logic [15:0] CMD_MEAS     = 16'h2C06;

  localparam logic [7:0] CRC_POLY = 8'h31;
  localparam logic [7:0] CRC_INIT = 8'hFF;

  typedef enum logic [2:0] {
    ST_RST_SEQ   = 3'd0,
    ST_RST_WAIT  = 3'd1,
    ST_IDLE      = 3'd2,
    ST_MEAS_SEQ  = 3'd3,
    ST_MEAS_WAIT = 3'd4,
    ST_READ_SEQ  = 3'd5,
    ST_CHECK     = 3'd6
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       nack;
  } op_t;

  // Op ROM: step 0 is always START, step 1 the address byte, last step STOP.
  function automatic op_t op_rom(input state_e st, input logic [3:0] step, input logic [6:0] addr);
    op_t         o;
    logic [15:0] cmd;
    o   = '{op: OP_STOP, data: 8'h00, nack: 1'b0};
    cmd = (st == ST_RST_SEQ) ? CMD_SOFT_RST : CMD_MEAS;
    if (step == 4'd0) begin
      o.op = OP_START;
    end else if (step == 4'd1) begin
      o.op   = OP_WRITE;
      o.data = {addr, (st == ST_READ_SEQ)};
    end else if (st == ST_READ_SEQ) begin
      if (step <= 4'd7) begin
        o.op   = OP_READ;
        o.nack = (step == 4'd7);
      end
    end else if (step <= 4'd3) begin
      o.op   = OP_WRITE;
      o.data = (step == 4'd2) ? cmd[15:8] : cmd[7:0];
    end
    return o;
  endfunction

  function automatic logic [3:0] last_step(input state_e st);
    return (st == ST_READ_SEQ) ? 4'd8 : 4'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sht30_crc8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sht30_crc8: combinational CRC-8 (0x31, init 0xFF) over two bytes      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sht30_crc8
  import sht30_pkg::*;
(
  input  logic [15:0] data,
  output logic [7:0]  crc
);

  always_comb begin
    crc = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      crc = (crc[7] ^ data[i]) ? ({crc[6:0], 1'b0} ^ CRC_POLY) : {crc[6:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sht30_meas_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sht30_meas_sched: soft reset + periodic/triggered SHT30 measurements  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sht30_meas_sched
  import sht30_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR     = 7'h44,
  parameter logic [25:0] T_RST_CYC    = 26'd75_000,
  parameter logic [25:0] T_MEAS_CYC   = 26'd750_000,
  parameter logic [25:0] T_PERIOD_CYC = 26'd50_000_000,
  parameter logic [3:0]  MAX_RETRY    = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        trig,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_data,
  output logic        cmd_nack,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack,
  output logic [15:0] t_code,
  output logic [15:0] h_code,
  output logic        data_valid,
  output logic        crc_err,
  output logic        bus_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [25:0] wait_q, wait_d;
  logic [25:0] per_q, per_d;
  logic [3:0]  retry_q, retry_d;
  logic        pending_q, pending_d;
  logic        abort_q, abort_d;
  logic        waiting_q, waiting_d;
  logic [47:0] rd_q, rd_d;
  logic        cmd_valid_q, cmd_valid_d;
  op_t         cmd_q, cmd_d;
  logic [15:0] t_code_q, t_code_d;
  logic [15:0] h_code_q, h_code_d;
  logic        data_valid_q, data_valid_d;
  logic        crc_err_q, crc_err_d;
  logic        bus_err_q, bus_err_d;
  logic        busy_q, busy_d;
  logic        fail;
  logic [4:0]  retry_inc;
  logic [7:0]  crc_t, crc_h;

  sht30_crc8 u_crc_t (.data(rd_q[47:32]), .crc(crc_t));
  sht30_crc8 u_crc_h (.data(rd_q[23:8]),  .crc(crc_h));

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    wait_d       = wait_q;
    per_d        = per_q;
    retry_d      = retry_q;
    pending_d    = pending_q;
    abort_d      = abort_q;
    waiting_d    = waiting_q;
    rd_d         = rd_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_d        = cmd_q;
    t_code_d     = t_code_q;
    h_code_d     = h_code_q;
    data_valid_d = 1'b0;
    crc_err_d    = 1'b0;
    bus_err_d    = bus_err_q;
    fail         = 1'b0;
    retry_inc    = {1'b0, retry_q} + 5'd1;

    if (!auto_en)            per_d = T_PERIOD_CYC - 26'd1;
    else if (per_q != '0)    per_d = per_q - 26'd1;
    if (trig && state_q != ST_IDLE) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (trig || pending_q || (auto_en && per_q == '0)) begin
          state_d   = ST_MEAS_SEQ;
          pending_d = 1'b0;
          per_d     = T_PERIOD_CYC - 26'd1;
        end
      end
      ST_RST_WAIT: begin
        if (wait_q == '0) state_d = ST_IDLE;
        else              wait_d  = wait_q - 26'd1;
      end
      ST_MEAS_WAIT: begin
        if (wait_q == '0) state_d = ST_READ_SEQ;
        else              wait_d  = wait_q - 26'd1;
      end
      ST_CHECK: begin
        if (crc_t == rd_q[31:24] && crc_h == rd_q[7:0]) begin
          t_code_d     = rd_q[47:32];
          h_code_d     = rd_q[23:8];
          data_valid_d = 1'b1;
          retry_d      = '0;
          state_d      = ST_IDLE;
        end else begin
          crc_err_d = 1'b1;
          fail      = 1'b1;
        end
      end
      default: begin
        // Sequence states: issue -> accepted -> response, one op at a time.
        if (!cmd_valid_q && !waiting_q) begin
          cmd_valid_d = 1'b1;
          cmd_d       = op_rom(state_q, step_q, DEV_ADDR);
        end else if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          waiting_d   = 1'b1;
        end else if (waiting_q && rsp_valid) begin
          waiting_d = 1'b0;
          if (cmd_q.op == OP_READ) rd_d = {rd_q[39:0], rsp_data};
          if (cmd_q.op == OP_STOP) begin
            if (abort_q) begin
              fail = 1'b1;
            end else if (state_q == ST_RST_SEQ) begin
              state_d = ST_RST_WAIT;
              wait_d  = T_RST_CYC;
            end else if (state_q == ST_MEAS_SEQ) begin
              state_d = ST_MEAS_WAIT;
              wait_d  = T_MEAS_CYC;
            end else begin
              state_d = ST_CHECK;
            end
          end else if (cmd_q.op == OP_WRITE && rsp_nack) begin
            abort_d = 1'b1;
            step_d  = last_step(state_q);
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
    endcase

    if (fail) begin
      if (retry_inc > {1'b0, MAX_RETRY}) begin
        bus_err_d = 1'b1;
        retry_d   = '0;
        state_d   = ST_RST_SEQ;
      end else begin
        retry_d = retry_inc[3:0];
        state_d = (state_q == ST_RST_SEQ) ? ST_RST_SEQ : ST_MEAS_SEQ;
      end
      step_d  = '0;
      abort_d = 1'b0;
    end
    if (state_d != state_q) begin
      step_d  = '0;
      abort_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RST_SEQ;
      step_q       <= '0;
      wait_q       <= '0;
      per_q        <= T_PERIOD_CYC - 26'd1;
      retry_q      <= '0;
      pending_q    <= 1'b0;
      abort_q      <= 1'b0;
      waiting_q    <= 1'b0;
      rd_q         <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= '0;
      t_code_q     <= '0;
      h_code_q     <= '0;
      data_valid_q <= 1'b0;
      crc_err_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      wait_q       <= wait_d;
      per_q        <= per_d;
      retry_q      <= retry_d;
      pending_q    <= pending_d;
      abort_q      <= abort_d;
      waiting_q    <= waiting_d;
      rd_q         <= rd_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      t_code_q     <= t_code_d;
      h_code_q     <= h_code_d;
      data_valid_q <= data_valid_d;
      crc_err_q    <= crc_err_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_q.op;
  assign cmd_data   = cmd_q.data;
  assign cmd_nack   = cmd_q.nack;
  assign t_code     = t_code_q;
  assign h_code     = h_code_q;
  assign data_valid = data_valid_q;
  assign crc_err    = crc_err_q;
  assign bus_err    = bus_err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sht30_meas_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sht30_meas_sched: byte-engine BFM, op-stream and result scoreboard |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sht30_meas_sched;

  localparam logic [25:0] T_RST  = 26'd100;
  localparam logic [25:0] T_MEAS = 26'd200;
  localparam logic [25:0] T_PER  = 26'd2000;
  localparam logic [1:0]  OP_START = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2, OP_STOP = 2'd3;

  logic        clk = 1'b0, rst = 1'b1, auto_en = 1'b0, trig = 1'b0;
  logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic [7:0]  rsp_data = 8'h00;
  logic        cmd_valid, cmd_nack, data_valid, crc_err, bus_err, busy;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [15:0] t_code, h_code;

  always #5 clk = ~clk;

  sht30_meas_sched #(
    .DEV_ADDR(7'h44), .T_RST_CYC(T_RST), .T_MEAS_CYC(T_MEAS),
    .T_PERIOD_CYC(T_PER), .MAX_RETRY(4'd3)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .trig(trig),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_nack(rsp_nack), .t_code(t_code), .h_code(h_code),
    .data_valid(data_valid), .crc_err(crc_err), .bus_err(bus_err), .busy(busy)
  );

  typedef struct { logic [10:0] op; int cyc; } trace_t;
  typedef struct { bit err; logic [15:0] t; logic [15:0] h; } res_t;

  int          n_tests = 0, n_fail = 0, n_dv = 0;
  int          cyc = 0, last_stop_rsp = 0, nack_budget = 0;
  bit          record = 1'b1;
  trace_t      trace[$];
  logic [10:0] exp_ops[$];
  logic [47:0] frames[$];
  res_t        sb[$];
  logic [15:0] mdl_t = 16'h0, mdl_h = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte-wise CRC: xor whole byte in, then eight shifts.
  function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    c = 8'hFF ^ a;
    repeat (8) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    c = c ^ b;
    repeat (8) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    return c;
  endfunction

  function automatic logic [47:0] good_frame(input logic [15:0] t, input logic [15:0] h);
    return {t, crc8(t[15:8], t[7:0]), h, crc8(h[15:8], h[7:0])};
  endfunction

  function automatic logic [10:0] enc(input logic [1:0] op, input logic [7:0] d, input logic n);
    return {op, (op == OP_WRITE) ? d : 8'h00, (op == OP_READ) ? n : 1'b0};
  endfunction

  task automatic score(input logic [47:0] f);
    res_t r;
    r.err = !(crc8(f[47:40], f[39:32]) == f[31:24] && crc8(f[23:16], f[15:8]) == f[7:0]);
    if (!r.err) begin
      mdl_t = f[47:32];
      mdl_h = f[23:8];
    end
    r.t = mdl_t;
    r.h = mdl_h;
    sb.push_back(r);
  endtask

  // kind: 0 soft reset, 1 measure, 2 read; abort = address byte NACKed
  task automatic push_seq(input int kind, input bit abort);
    exp_ops.push_back(enc(OP_START, 8'h00, 1'b0));
    if (kind == 0) begin
      exp_ops.push_back(enc(OP_WRITE, 8'h88, 1'b0));
      exp_ops.push_back(enc(OP_WRITE, 8'h30, 1'b0));
      exp_ops.push_back(enc(OP_WRITE, 8'hA2, 1'b0));
    end else if (kind == 1) begin
      exp_ops.push_back(enc(OP_WRITE, 8'h88, 1'b0));
      if (!abort) begin
        exp_ops.push_back(enc(OP_WRITE, 8'h2C, 1'b0));
        exp_ops.push_back(enc(OP_WRITE, 8'h06, 1'b0));
      end
    end else begin
      exp_ops.push_back(enc(OP_WRITE, 8'h89, 1'b0));
      for (int i = 0; i < 6; i++) exp_ops.push_back(enc(OP_READ, 8'h00, i == 5));
    end
    exp_ops.push_back(enc(OP_STOP, 8'h00, 1'b0));
  endtask

  task automatic drain(input string tag, input int budget);
    int          waited;
    trace_t      tr;
    logic [10:0] e;
    waited = 0;
    while (exp_ops.size() > 0) begin
      while (trace.size() == 0 && waited < budget) begin
        @(posedge clk);
        waited++;
      end
      if (trace.size() == 0) begin
        chk({tag, "_timeout"}, 32'd0, 32'd1);
        exp_ops.delete();
      end else begin
        tr = trace.pop_front();
        e  = exp_ops.pop_front();
        chk(tag, {21'd0, tr.op}, {21'd0, e});
      end
    end
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_busy_rise(output int c, output bit ok);
    logic prev;
    int   n;
    prev = busy;
    ok   = 1'b0;
    c    = 0;
    n    = 0;
    while (n < 5000 && !ok) begin
      @(posedge clk);
      #3;
      if (busy && !prev) begin
        c  = cyc;
        ok = 1'b1;
      end
      prev = busy;
      n++;
    end
  endtask

  // Byte-engine BFM: random ready latency 0-3, response 1-3 cycles after accept.
  initial begin : bfm
    logic [10:0] hold;
    logic [47:0] fr;
    logic [1:0]  cur_op;
    logic [7:0]  cur_data;
    bit          outst, seen;
    int          lat, rcnt, ridx;
    outst = 0; seen = 0; lat = 0; rcnt = 0; ridx = 0;
    fr = '0; hold = '0; cur_op = OP_START; cur_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
      if (rst) begin
        outst = 0;
        seen  = 0;
      end else if (outst) begin
        chk("one_outstanding", {31'd0, cmd_valid}, 32'd0);
        if (rcnt > 0) begin
          rcnt--;
        end else begin
          outst     = 0;
          rsp_valid = 1'b1;
          case (cur_op)
            OP_START: ridx = 0;
            OP_WRITE: if (nack_budget > 0 && cur_data == 8'h88) begin
              rsp_nack = 1'b1;
              nack_budget--;
            end
            OP_READ: begin
              if (ridx == 0) begin
                fr = (frames.size() > 0) ? frames.pop_front()
                                         : good_frame(16'($urandom), 16'($urandom));
                score(fr);
              end
              rsp_data = fr[47 - 8*ridx -: 8];
              ridx++;
            end
            default: last_stop_rsp = cyc;
          endcase
        end
      end else if (cmd_valid) begin
        if (!seen) begin
          seen = 1;
          lat  = $urandom_range(0, 3);
          hold = {cmd_op, cmd_data, cmd_nack};
        end else begin
          chk("hold_stable", {21'd0, cmd_op, cmd_data, cmd_nack}, {21'd0, hold});
        end
        if (lat == 0) begin
          cmd_ready = 1'b1;
          outst     = 1;
          seen      = 0;
          rcnt      = $urandom_range(0, 2);
          cur_op    = cmd_op;
          cur_data  = cmd_data;
          if (record) trace.push_back('{enc(cmd_op, cmd_data, cmd_nack), cyc});
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin : mon
    res_t r;
    bit   prev;
    prev = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        sb.delete();
      end else if (data_valid || crc_err) begin
        if (data_valid) n_dv++;
        chk("pulse_width", {31'd0, prev}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk("result_crc_err", {31'd0, crc_err}, {31'd0, r.err});
          chk("result_data_valid", {31'd0, data_valid}, {31'd0, !r.err});
          chk("result_t_code", {16'd0, t_code}, {16'd0, r.t});
          chk("result_h_code", {16'd0, h_code}, {16'd0, r.h});
        end
      end
      prev = data_valid | crc_err;
    end
  end

  initial begin : watchdog
    #(900_000);
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int gap, r0, r1, r2, n;
    bit ok0, ok1, ok2;

    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_t_code", {16'd0, t_code}, 32'd0);
    chk("rst_h_code", {16'd0, h_code}, 32'd0);
    chk("rst_flags", {29'd0, data_valid, crc_err, bus_err}, 32'd0);
    rst = 1'b0;

    // Soft reset stream, then the post-reset wait before the next op
    push_seq(0, 1'b0);
    drain("rst_seq", 400);
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    frames.push_back(48'hBEEF92_666693);
    n = 0;
    while (trace.size() == 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    gap = (trace.size() > 0) ? trace[0].cyc - last_stop_rsp : 0;
    chk("rst_wait_gap_min", {31'd0, gap >= int'(T_RST) + 3}, 32'd1);
    chk("rst_wait_gap_max", {31'd0, gap <= int'(T_RST) + 8}, 32'd1);

    // Good measurement: BEEF / 6666
    push_seq(1, 1'b0);
    push_seq(2, 1'b0);
    drain("meas_read_good", 2000);
    wait_sb("good", 100);
    chk("t_code_beef", {16'd0, t_code}, 32'h0000_BEEF);
    chk("h_code_6666", {16'd0, h_code}, 32'h0000_6666);
    chk("dv_count", n_dv, 1);

    // CRC error on temperature, retry succeeds with fresh data
    wait_idle("crc", 200);
    frames.push_back(48'hBEEF93_666693);
    frames.push_back(good_frame(16'h1234, 16'h5678));
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    push_seq(1, 1'b0); push_seq(2, 1'b0);
    push_seq(1, 1'b0); push_seq(2, 1'b0);
    drain("crc_retry", 4000);
    wait_sb("crc", 100);
    chk("t_after_retry", {16'd0, t_code}, 32'h0000_1234);
    chk("h_after_retry", {16'd0, h_code}, 32'h0000_5678);

    // Address NACK on every measure attempt: 4 tries, then bus_err + soft reset
    wait_idle("nack", 200);
    nack_budget = 4;
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    for (int i = 0; i < 4; i++) push_seq(1, 1'b1);
    push_seq(0, 1'b0);
    drain("nack_retry", 2000);
    chk("bus_err_set", {31'd0, bus_err}, 32'd1);
    wait_idle("nack_rst", 400);

    // Two trigs during MEAS_WAIT -> exactly one extra measurement
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    push_seq(1, 1'b0);
    drain("pend_meas", 1000);
    repeat (20) @(negedge clk);
    trig = 1'b1; @(negedge clk) trig = 1'b0;
    repeat (5) @(negedge clk);
    trig = 1'b1; @(negedge clk) trig = 1'b0;
    push_seq(2, 1'b0); push_seq(1, 1'b0); push_seq(2, 1'b0);
    drain("pend_extra", 3000);
    wait_sb("pend", 100);
    repeat (700) @(posedge clk);
    chk("no_third_meas", trace.size(), 0);
    chk("pend_idle", {31'd0, busy}, 32'd0);

    // Periodic mode: starts exactly one period apart
    record = 1'b0;
    trace.delete();
    @(negedge clk) auto_en = 1'b1;
    wait_busy_rise(r0, ok0);
    wait_busy_rise(r1, ok1);
    wait_busy_rise(r2, ok2);
    chk("period_rises_seen", {29'd0, ok0, ok1, ok2}, 32'd7);
    chk("period_1", r1 - r0, int'(T_PER));
    chk("period_2", r2 - r1, int'(T_PER));
    chk("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset in the middle of a read sequence
    n = 0;
    while (!(cmd_valid && cmd_op == OP_READ) && n < 5000) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk("saw_read_op", {31'd0, cmd_valid && cmd_op == OP_READ}, 32'd1);
    @(negedge clk) rst = 1'b1;
    auto_en = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("midrst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("midrst_codes", {t_code, h_code}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    trace.delete();
    record = 1'b1;
    @(negedge clk) rst = 1'b0;
    push_seq(0, 1'b0);
    drain("rst_restart", 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
